// File: rtl/hamming_pkg.sv
// Shared constants, data-bit position table and error classes for the Hamming(39,32) SEC-DED decoder.
package hamming_pkg;

    localparam int CW_W  = 39;
    localparam int SYN_W = 6;

    // Codeword position of each data bit: all non-power-of-two positions 3..38, ascending.
    localparam logic [SYN_W-1:0] DATA_POS [32] = '{
        6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
        6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
        6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
        6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
    };

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        SEC   = 2'd1,
        DED   = 2'd2
    } err_class_e;

endpackage

// File: rtl/hamming_secded_syndrome.sv
// Combinational syndrome (XOR of set-bit indices 1..38) and overall parity of a 39-bit codeword.
module hamming_secded_syndrome
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]  cw_i,
    output logic [SYN_W-1:0] syn_o,
    output logic             par_o
);

    always_comb begin
        syn_o = '0;
        for (int i = 1; i < CW_W; i++) begin
            if (cw_i[i]) begin
                syn_o = syn_o ^ SYN_W'(i);
            end
        end
        par_o = ^cw_i;
    end

endmodule

// File: rtl/hamming_secded_dec_pipe.sv
// Two-stage SEC-DED decoder with valid/ready flow control (stage 1: syndrome, stage 2: correction).
// Saturating sec/ded counters exist only when HAMMING_ERR_CNT_EN is defined.
module hamming_secded_dec_pipe
    import hamming_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW_W-1:0]   in_cw,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sec,
    output logic              out_ded,
    output logic [SYN_W-1:0]  out_syn,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt
);

    logic              adv;
    logic [SYN_W-1:0]  syn_d;
    logic              par_d;

    logic              s1_valid_q;
    logic [CW_W-1:0]   s1_cw_q;
    logic [SYN_W-1:0]  s1_syn_q;
    logic              s1_par_q;

    err_class_e        cls_d;
    logic [CW_W-1:0]   fixed_cw;
    logic [DATA_W-1:0] data_d;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_sec_q;
    logic              out_ded_q;
    logic [SYN_W-1:0]  out_syn_q;

    // Both stages move together; a held output freezes the whole pipe.
    assign adv      = out_ready | ~out_valid_q;
    assign in_ready = adv;

    hamming_secded_syndrome u_syndrome (
        .cw_i  (in_cw),
        .syn_o (syn_d),
        .par_o (par_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            s1_valid_q <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
        end
    end

    // NOTE: stage-1 payload has no reset; s1_valid_q alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (adv && in_valid) begin
            s1_cw_q  <= in_cw;
            s1_syn_q <= syn_d;
            s1_par_q <= par_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
        cls_d    = CLEAN;
        fixed_cw = s1_cw_q;
        data_d   = '0;
        if (s1_par_q) begin
            if (s1_syn_q == '0) begin
                cls_d = SEC;
            end else if (s1_syn_q <= SYN_W'(CW_W - 1)) begin
                cls_d              = SEC;
                fixed_cw[s1_syn_q] = ~s1_cw_q[s1_syn_q];
            end else begin
                cls_d = DED;
            end
        end else if (s1_syn_q != '0) begin
            cls_d = DED;
        end
        for (int j = 0; j < DATA_W; j++) begin
            data_d[j] = fixed_cw[DATA_POS[j]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sec_q   <= 1'b0;
            out_ded_q   <= 1'b0;
            out_syn_q   <= '0;
        end else if (adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= data_d;
                out_sec_q  <= (cls_d == SEC);
                out_ded_q  <= (cls_d == DED);
                out_syn_q  <= s1_syn_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sec   = out_sec_q;
    assign out_ded   = out_ded_q;
    assign out_syn   = out_syn_q;

`ifdef HAMMING_ERR_CNT_EN
    logic             xfer;
    logic [CNT_W-1:0] sec_cnt_q;
    logic [CNT_W-1:0] ded_cnt_q;

    assign xfer = out_valid_q & out_ready;

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else if (clr_cnt) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else if (xfer) begin
            if (out_sec_q && sec_cnt_q != '1) begin
                sec_cnt_q <= sec_cnt_q + CNT_W'(1);
            end
            if (out_ded_q && ded_cnt_q != '1) begin
                ded_cnt_q <= ded_cnt_q + CNT_W'(1);
            end
        end
    end

    assign sec_cnt = sec_cnt_q;
    assign ded_cnt = ded_cnt_q;
`else
    logic unused_clr_cnt;

    assign unused_clr_cnt = clr_cnt;
    assign sec_cnt        = '0;
    assign ded_cnt        = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_dec_pipe.sv
// Self-checking bench for hamming_secded_dec_pipe: directed table, stall/counter/reset sequences, random traffic vs model.
module tb_hamming_secded_dec_pipe;

`ifdef HAMMING_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int TB_CNT_W = 2;
    localparam int CNT_MAX  = 3;

    typedef struct packed {
        logic [31:0] data;
        logic        sec;
        logic        ded;
        logic [5:0]  syn;
    } res_t;

    typedef struct {
        logic [31:0] data;
        logic [38:0] flips;
        res_t        exp;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [38:0]         in_cw;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_sec;
    logic                out_ded;
    logic [5:0]          out_syn;
    logic                clr_cnt;
    logic [TB_CNT_W-1:0] sec_cnt;
    logic [TB_CNT_W-1:0] ded_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_sec = 0;
    int exp_ded = 0;

    bit   mon_en = 1'b0;
    bit   prev_stall = 1'b0;
    res_t held;
    res_t mon_r;
    res_t exp_q [$];

    hamming_secded_dec_pipe #(.DATA_W(32), .CNT_W(TB_CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_cw     (in_cw),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sec   (out_sec),
        .out_ded   (out_ded),
        .out_syn   (out_syn),
        .clr_cnt   (clr_cnt),
        .sec_cnt   (sec_cnt),
        .ded_cnt   (ded_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_pow2(input int pos);
        return (pos & (pos - 1)) == 0;
    endfunction

    // Encoder: data into non-power-of-two slots, parity slots set to cancel the syndrome, bit 0 evens it out.
    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [38:0] c = '0;
        int k = 0;
        int s = 0;
        for (int pos = 3; pos <= 38; pos++) begin
            if (!is_pow2(pos)) begin
                c[pos] = d[k];
                k++;
            end
        end
        for (int pos = 1; pos <= 38; pos++) if (c[pos]) s ^= pos;
        for (int b = 0; b < 6; b++) if (s[b]) c[1 << b] = 1'b1;
        c[0] = ^c[38:1];
        return c;
    endfunction

    function automatic res_t model_dec(input logic [38:0] cw);
        res_t r;
        logic [38:0] c = cw;
        int s = 0;
        int p = 0;
        int k = 0;
        for (int i = 0; i < 39; i++) begin
            p ^= int'(cw[i]);
            if (i > 0 && cw[i]) s ^= i;
        end
        r.sec = 1'b0;
        r.ded = 1'b0;
        if (p == 1 && s == 0) r.sec = 1'b1;
        else if (p == 1 && s <= 38) begin
            r.sec = 1'b1;
            c[s]  = ~c[s];
        end else if (p == 1 || s != 0) r.ded = 1'b1;
        r.data = '0;
        for (int pos = 3; pos <= 38; pos++) begin
            if (!is_pow2(pos)) begin
                r.data[k] = c[pos];
                k++;
            end
        end
        r.syn = s[5:0];
        return r;
    endfunction

    function automatic void note_xfer(input res_t r);
        if (CNT_EN) begin
            if (r.sec && exp_sec < CNT_MAX) exp_sec++;
            if (r.ded && exp_ded < CNT_MAX) exp_ded++;
        end
    endfunction

    function automatic res_t out_now();
        return {out_data, out_sec, out_ded, out_syn};
    endfunction

    // Scoreboard for random traffic: FIFO order, hold-while-stalled, nothing unexpected.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) check("rand_hold", out_now(), held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_out", 1, 0);
                end else begin
                    mon_r = exp_q.pop_front();
                    check("rand_out", out_now(), mon_r);
                    note_xfer(mon_r);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model_dec(in_cw));
            prev_stall = out_valid && !out_ready;
            held       = out_now();
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    vec_t vecs [9];

    task automatic run_table();
        vecs[0] = '{32'h0000000F, 39'h0,                 '{32'h0000000F, 1'b0, 1'b0, 6'd0}};
        vecs[1] = '{32'h0000000F, 39'h8,                 '{32'h0000000F, 1'b1, 1'b0, 6'd3}};
        vecs[2] = '{32'h0000000F, 39'h1,                 '{32'h0000000F, 1'b1, 1'b0, 6'd0}};
        vecs[3] = '{32'h0000000F, 39'h28,                '{32'h0000000C, 1'b0, 1'b1, 6'd6}};
        vecs[4] = '{32'hFFFFFFFF, 39'h0,                 '{32'hFFFFFFFF, 1'b0, 1'b0, 6'd0}};
        vecs[5] = '{32'hFFFFFFFF, 39'd1 << 38,           '{32'hFFFFFFFF, 1'b1, 1'b0, 6'd38}};
        vecs[6] = '{32'h00000000, (39'd1 << 32) | 39'h81, '{32'h00000008, 1'b0, 1'b1, 6'd39}};
        vecs[7] = '{32'h0000000F, 39'h6,                 '{32'h0000000F, 1'b0, 1'b1, 6'd3}};
        vecs[8] = '{32'hA5A5A5A5, 39'd1 << 20,           '{32'hA5A5A5A5, 1'b1, 1'b0, 6'd20}};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            in_cw    = encode(vecs[i].data) ^ vecs[i].flips;
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk); #1;
            check($sformatf("tbl%0d_valid", i), out_valid, 1);
            check($sformatf("tbl%0d_out", i), out_now(), vecs[i].exp);
            note_xfer(vecs[i].exp);
            @(posedge clk); #1;
            check($sformatf("tbl%0d_drained", i), out_valid, 0);
            check($sformatf("tbl%0d_sec_cnt", i), sec_cnt, exp_sec);
            check($sformatf("tbl%0d_ded_cnt", i), ded_cnt, exp_ded);
        end
    endtask

    task automatic run_stall();
        logic [38:0] w [3];
        res_t e [3];
        int n_in = 0;
        int n_out = 0;
        int n_stall = 0;
        for (int k = 0; k < 3; k++) begin
            w[k] = encode($urandom) ^ (39'd1 << $urandom_range(0, 38));
            e[k] = model_dec(w[k]);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_cw     = w[0];
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 20 && n_out < 3; cyc++) begin
            @(negedge clk);
            if (out_valid && !out_ready) begin
                n_stall++;
                check("stall_in_ready", in_ready, 0);
                check("stall_hold", out_now(), e[0]);
            end
            if (out_valid && out_ready) begin
                check($sformatf("stall_out%0d", n_out), out_now(), e[n_out]);
                note_xfer(e[n_out]);
                n_out++;
            end
            if (in_valid && in_ready) n_in++;
            @(posedge clk); #1;
            if (n_in < 3) in_cw = w[n_in];
            else in_valid = 1'b0;
            out_ready = (cyc >= 4);
        end
        in_valid = 1'b0;
        check("stall_cycles", n_stall, 3);
        check("stall_delivered", n_out, 3);
    endtask

    task automatic run_counters();
        @(posedge clk); #1;
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        exp_sec = 0;
        exp_ded = 0;
        check("clr_sec_cnt", sec_cnt, exp_sec);
        check("clr_ded_cnt", ded_cnt, exp_ded);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_cw    = encode($urandom) ^ (39'd1 << $urandom_range(1, 38));
            in_valid = 1'b1;
            note_xfer(model_dec(in_cw));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("sat_sec_cnt", sec_cnt, exp_sec);
        check("sat_sec_cnt_value", sec_cnt, CNT_EN ? CNT_MAX : 0);
        in_cw    = encode(32'h12345678) ^ 39'h10;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("clr_race_sec", out_sec, 1);
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        exp_sec = 0;
        exp_ded = 0;
        check("clr_race_sec_cnt", sec_cnt, exp_sec);
    endtask

    task automatic run_reset_inflight();
        int seen = 0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_cw    = encode(32'hDEADBEEF) ^ 39'h100;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_cw = encode(32'hCAFEF00D);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("inflight_valid_before_rst", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("inflight_valid_in_rst", out_valid, 0);
        check("inflight_in_ready_in_rst", in_ready, 1);
        @(posedge clk); #1;
        rst     = 1'b0;
        exp_sec = 0;
        exp_ded = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("inflight_never_output", seen, 0);
        check("inflight_sec_cnt", sec_cnt, exp_sec);
        check("inflight_ded_cnt", ded_cnt, exp_ded);
    endtask

    task automatic run_random();
        logic [38:0] cw;
        int n_ready_low = 0;
        int drain = 0;
        @(posedge clk); #1;
        mon_en    = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_cw    = encode($urandom) ^ (39'd1 << $urandom_range(0, 38));
            in_valid = 1'b1;
            @(negedge clk);
            if (!in_ready) n_ready_low++;
            @(posedge clk); #1;
        end
        check("burst_in_ready", n_ready_low, 0);
        for (int k = 0; k < 1500; k++) begin
            cw = encode($urandom);
            for (int f = $urandom_range(0, 3); f > 0; f--) cw[$urandom_range(0, 38)] ^= 1'b1;
            in_cw     = cw;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && drain < 20) begin
            @(posedge clk); #1;
            drain++;
        end
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("rand_drained", exp_q.size(), 0);
        check("rand_sec_cnt", sec_cnt, exp_sec);
        check("rand_ded_cnt", ded_cnt, exp_ded);
    endtask

    initial begin
        rst       = 1'b1;
        in_cw     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_outputs", out_now(), '0);
        check("rst_sec_cnt", sec_cnt, 0);
        check("rst_ded_cnt", ded_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        run_table();
        run_stall();
        run_counters();
        run_reset_inflight();
        run_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
